tpu_command_feeder: RTL
=======================

Name: tpu_command_feeder

Overview:
Upstream stage of the text processing unit (TPU). It receives a raw byte stream from the host UART receiver and parses it into framed TPU commands (opcode byte plus argument bytes). Parsed commands are buffered in a small FIFO. A dispatcher issues them to the TPU over the execute/command/busy handshake and holds each command word stable for the TPU's whole multi-cycle execution.

Parameters:
FIFO_DEPTH, 4, number of buffered 48-bit commands; power of two, at least 2.
BYTE_TIMEOUT, 1000000, clk cycles allowed between bytes of one command before the partial command is discarded.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_valid  in  1  one-cycle strobe: rx_data holds a new byte
rx_data  in  8  received byte
tpu_busy  in  1  TPU busy output
execute  out  1  one-cycle command strobe to the TPU
command  out  48  command word to the TPU
fifo_level  out  $clog2(FIFO_DEPTH)+1  number of queued commands
overflow  out  1  one-cycle pulse: a completed command was dropped because the FIFO was full
bad_opcode  out  1  one-cycle pulse: an unknown opcode byte was discarded

Behaviour:
Reset values:
- execute=0, command=0, fifo_level=0, overflow=0, bad_opcode=0.
- Parser returns to OPCODE; dispatcher returns to IDLE; the FIFO is emptied.
- Reset mid-command or mid-dispatch drops everything at the next edge.

Parser states: OPCODE, ARGS.
- In OPCODE, an rx_valid byte is decoded:
  - `TPU_CLEARSCREEN: 0 arguments.
  - `TPU_PRINT: 1 argument (character code).
  - `TPU_LOCATE: 2 arguments (x, y).
  - `TPU_SETATTR: 2 arguments (attr1, attr2).
  - `TPU_SETMASK: 3 arguments (mask bits 7:0, 15:8, 23:16).
  - Any other byte: pulse bad_opcode, stay in OPCODE.
- A 0-argument opcode completes immediately; otherwise go to ARGS with a remaining-argument counter.
- Packing: command[7:0]=opcode, [15:8]=arg0, [23:16]=arg1, [31:24]=arg2. Unused bytes and [47:32] are 0.
- Completion: the word is pushed on the edge after the last byte. If the FIFO is full, pulse overflow, drop the word, and return to OPCODE.
- Timeout: in ARGS, a cycle counter resets on each byte. When it reaches BYTE_TIMEOUT with no new byte, discard the partial command and return to OPCODE. No pulse is raised.

FIFO:
- Synchronous, first-word fall-through to the dispatcher.
- A push and a pop in the same cycle are both honoured, and fifo_level is unchanged.
- A push is accepted when full only if a pop happens in the same cycle.

Dispatcher states: IDLE, ISSUE, GUARD, WAIT_DONE.
- IDLE: if the FIFO is non-empty and tpu_busy=0, load command from the FIFO head, pop, and go to ISSUE.
- ISSUE: execute=1 for exactly this one cycle; go to GUARD.
- GUARD: one cycle, ignoring tpu_busy. The TPU raises busy only one edge after sampling execute. Go to WAIT_DONE.
- WAIT_DONE: hold command constant; when tpu_busy=0, go to IDLE.
- Latency: from the push of the first command into an empty FIFO with an idle TPU, the execute pulse occurs 2 cycles later (IDLE→ISSUE edge, then the ISSUE cycle).
- command is never changed while not in IDLE. The TPU reads argument bytes during later states, so the word must stay stable until busy drops.
- Only valid opcodes reach the TPU, so busy always rises after execute.

Test Plan:
- Bytes `TPU_PRINT, 0x41 with the TPU model idle → one execute pulse with command=0x00000000_41<PRINT>. command stays stable until tpu_busy falls.
- Bytes `TPU_LOCATE, 0x05, 0x0A, then `TPU_SETMASK, 0xFF, 0x00, 0xFF → two dispatches in order, command[23:8]=0x0A05 then command[31:8]=0xFF00FF. The second execute comes only after busy has dropped.
- `TPU_CLEARSCREEN with TPU busy held high for 3000 cycles, then 5 PRINT commands streamed → fifo_level saturates at 4; the 5th completion pulses overflow once; 4 PRINTs are issued after busy drops.
- Byte 0xEE (not an opcode) then `TPU_PRINT, 0x42 → bad_opcode pulses once; only the PRINT 0x42 is dispatched.
- BYTE_TIMEOUT=16: `TPU_LOCATE, 0x03, then a 20-cycle gap, then `TPU_PRINT, 0x43 → the LOCATE is discarded silently; only the PRINT is dispatched.
- Reset asserted during WAIT_DONE with 2 commands queued → next cycle execute=0, command=0, fifo_level=0; no later dispatch.

Source files
------------

// File: rtl/tpu_command_feeder.sv
// Parses host UART bytes into 48-bit TPU commands, queues them, and dispatches them over execute/busy.
// Latency: a completed command into an empty queue with an idle TPU raises execute 2 cycles after its push.
// Backpressure: none toward the UART; a completed command that finds the FIFO full is dropped with an overflow pulse.

`ifndef TPU_CLEARSCREEN
`define TPU_CLEARSCREEN 8'h01
`endif
`ifndef TPU_PRINT
`define TPU_PRINT 8'h02
`endif
`ifndef TPU_LOCATE
`define TPU_LOCATE 8'h03
`endif
`ifndef TPU_SETATTR
`define TPU_SETATTR 8'h04
`endif
`ifndef TPU_SETMASK
`define TPU_SETMASK 8'h05
`endif

module tpu_command_feeder #(
    parameter int FIFO_DEPTH   = 4,
    parameter int BYTE_TIMEOUT = 1000000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx_valid,
    input  logic [7:0]                    rx_data,
    input  logic                          tpu_busy,
    output logic                          execute,
    output logic [47:0]                   command,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          bad_opcode
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(BYTE_TIMEOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'(BYTE_TIMEOUT - 1);
    localparam logic [LW-1:0] LFULL = LW'(FIFO_DEPTH);

    localparam logic P_OPCODE = 1'b0;
    localparam logic P_ARGS   = 1'b1;

    localparam logic [1:0] D_IDLE      = 2'd0;
    localparam logic [1:0] D_ISSUE     = 2'd1;
    localparam logic [1:0] D_GUARD     = 2'd2;
    localparam logic [1:0] D_WAIT_DONE = 2'd3;

    logic          pstate;
    logic [1:0]    rem;
    logic [1:0]    idx;
    logic [31:0]   word_q;
    logic [TW-1:0] timer;

    logic          op_known;
    logic [1:0]    op_nargs;
    logic [31:0]   next_word;
    logic          push;
    logic [47:0]   push_word;

    logic [47:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          full;
    logic          pop;
    logic          push_ok;

    logic [1:0]    dstate;

    // Decode the incoming byte as an opcode and report its argument count.
    always_comb begin
        op_known = 1'b1;
        op_nargs = 2'd0;
        case (rx_data)
            `TPU_CLEARSCREEN: op_nargs = 2'd0;
            `TPU_PRINT:       op_nargs = 2'd1;
            `TPU_LOCATE:      op_nargs = 2'd2;
            `TPU_SETATTR:     op_nargs = 2'd2;
            `TPU_SETMASK:     op_nargs = 2'd3;
            default:          op_known = 1'b0;
        endcase
    end

    // Form the completed command word when the final byte of a command arrives.
    always_comb begin
        next_word = word_q | (32'(rx_data) << {idx, 3'b000});
        push      = 1'b0;
        push_word = '0;
        if (pstate == P_OPCODE && rx_valid && op_known && op_nargs == 2'd0) begin
            push      = 1'b1;
            push_word = {40'h0, rx_data};
        end else if (pstate == P_ARGS && rx_valid && rem == 2'd1) begin
            push      = 1'b1;
            push_word = {16'h0, next_word};
        end
    end

    assign full    = (count == LFULL);
    assign pop     = (dstate == D_IDLE) && (count != '0) && !tpu_busy;
    assign push_ok = push && (!full || pop);

    // Parser: collect argument bytes, abandon a stalled command, flag bad opcodes and drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            pstate     <= P_OPCODE;
            rem        <= 2'd0;
            idx        <= 2'd0;
            word_q     <= '0;
            timer      <= '0;
            overflow   <= 1'b0;
            bad_opcode <= 1'b0;
        end else begin
            overflow   <= push && !push_ok;
            bad_opcode <= (pstate == P_OPCODE) && rx_valid && !op_known;
            case (pstate)
                P_OPCODE: begin
                    if (rx_valid && op_known && op_nargs != 2'd0) begin
                        pstate <= P_ARGS;
                        rem    <= op_nargs;
                        idx    <= 2'd1;
                        word_q <= {24'h0, rx_data};
                        timer  <= '0;
                    end
                end
                default: begin
                    if (rx_valid) begin
                        timer <= '0;
                        if (rem == 2'd1) begin
                            pstate <= P_OPCODE;
                        end else begin
                            rem    <= rem - 2'd1;
                            idx    <= idx + 2'd1;
                            word_q <= next_word;
                        end
                    end else if (timer == TLAST) begin
                        pstate <= P_OPCODE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
            endcase
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_word;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the level unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      count <= count + 1'b1;
            else if (pop && !push_ok) count <= count - 1'b1;
        end
    end

    // Dispatcher: load the head word, strobe execute once, then hold the word until busy drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            dstate  <= D_IDLE;
            command <= '0;
        end else begin
            case (dstate)
                D_IDLE: begin
                    if (pop) begin
                        command <= mem[rd_ptr];
                        dstate  <= D_ISSUE;
                    end
                end
                D_ISSUE: dstate <= D_GUARD;
                D_GUARD: dstate <= D_WAIT_DONE;
                default: if (!tpu_busy) dstate <= D_IDLE;
            endcase
        end
    end

    assign execute    = (dstate == D_ISSUE);
    assign fifo_level = count;

endmodule
